// File: rtl/vx_alu_batch_pkg.sv
// Shared constants, sideband layout and sizing helpers for the ALU request batcher.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

package vx_alu_batch_pkg;

  localparam int DEF_NUM_THREADS = `NUM_THREADS;
  localparam int DEF_NUM_LANES   = 2;

  localparam int UUID_BITS   = 44;
  localparam int NW_BITS     = 2;
  localparam int PC_BITS     = 32;
  localparam int ALU_OP_BITS = 4;
  localparam int MOD_BITS    = 3;
  localparam int IMM_BITS    = 32;
  localparam int NR_BITS     = 5;
  localparam int FUNC3_BITS  = 3;
  localparam int FUNC7_BITS  = 7;
  localparam int XLEN        = 32;

  function automatic int calc_num_batches(input int nt, input int nl);
    return nt / nl;
  endfunction

  function automatic int calc_batch_bits(input int nt, input int nl);
    int nb;
    nb = nt / nl;
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  localparam int NUM_BATCHES = calc_num_batches(DEF_NUM_THREADS, DEF_NUM_LANES);
  localparam int BATCH_BITS  = calc_batch_bits(DEF_NUM_THREADS, DEF_NUM_LANES);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  // Request fields whose width does not depend on the thread count.
  typedef struct packed {
    logic [UUID_BITS-1:0]   uuid;
    logic [NW_BITS-1:0]     wid;
    logic [PC_BITS-1:0]     pc;
    logic [PC_BITS-1:0]     next_pc;
    logic [ALU_OP_BITS-1:0] op_type;
    logic [MOD_BITS-1:0]    op_mod;
    logic                   use_pc;
    logic                   use_imm;
    logic [IMM_BITS-1:0]    imm;
    logic [NR_BITS-1:0]     rd;
    logic                   wb;
    logic [FUNC3_BITS-1:0]  func3;
    logic [FUNC7_BITS-1:0]  func7;
  } req_side_t;

endpackage

// File: rtl/vx_alu_batch_sel.sv
// Finds the next non-empty batch strictly above the current one and flags the final batch.
module vx_alu_batch_sel
  import vx_alu_batch_pkg::*;
#(
  parameter int NUM_BATCHES = 2,
  parameter int BATCH_BITS  = 1
) (
  input  logic [NUM_BATCHES-1:0] bmask_i,
  input  logic [BATCH_BITS-1:0]  cur_i,
  output logic [BATCH_BITS-1:0]  next_o,
  output logic                   last_o
);

  logic [NUM_BATCHES-1:0] above;

  for (genvar gi = 0; gi < NUM_BATCHES; gi++) begin : g_above
    assign above[gi] = bmask_i[gi] && (gi > int'(cur_i));
  end

  // Descending scan leaves the lowest qualifying index in next_o.
  always_comb begin
    next_o = '0;
    for (int b = NUM_BATCHES - 1; b >= 0; b--) begin
      if (above[b]) begin
        next_o = BATCH_BITS'(b);
      end
    end
  end

  assign last_o = ~|above;

endmodule

// File: rtl/vx_alu_req_batcher.sv
// Holds one full-warp ALU request and replays it as NUM_LANES-wide batches, skipping empty ones.
module vx_alu_req_batcher
  import vx_alu_batch_pkg::*;
#(
  parameter  int NUM_THREADS = DEF_NUM_THREADS,
  parameter  int NUM_LANES   = DEF_NUM_LANES,
  localparam int NUM_BATCHES = calc_num_batches(NUM_THREADS, NUM_LANES),
  localparam int BATCH_BITS  = calc_batch_bits(NUM_THREADS, NUM_LANES),
  localparam int TID_BITS    = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,

  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [UUID_BITS-1:0]              in_uuid,
  input  logic [NW_BITS-1:0]                in_wid,
  input  logic [NUM_THREADS-1:0]            in_tmask,
  input  logic [PC_BITS-1:0]                in_PC,
  input  logic [PC_BITS-1:0]                in_next_PC,
  input  logic [ALU_OP_BITS-1:0]            in_op_type,
  input  logic [MOD_BITS-1:0]               in_op_mod,
  input  logic                              in_use_PC,
  input  logic                              in_use_imm,
  input  logic [IMM_BITS-1:0]               in_imm,
  input  logic [TID_BITS-1:0]               in_tid,
  input  logic [NR_BITS-1:0]                in_rd,
  input  logic                              in_wb,
  input  logic [FUNC3_BITS-1:0]             in_func3,
  input  logic [FUNC7_BITS-1:0]             in_func7,
  input  logic [NUM_THREADS-1:0][XLEN-1:0]  in_rs1_data,
  input  logic [NUM_THREADS-1:0][XLEN-1:0]  in_rs2_data,

  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [UUID_BITS-1:0]              out_uuid,
  output logic [NW_BITS-1:0]                out_wid,
  output logic [NUM_LANES-1:0]              out_tmask,
  output logic [PC_BITS-1:0]                out_PC,
  output logic [PC_BITS-1:0]                out_next_PC,
  output logic [ALU_OP_BITS-1:0]            out_op_type,
  output logic [MOD_BITS-1:0]               out_op_mod,
  output logic                              out_use_PC,
  output logic                              out_use_imm,
  output logic [IMM_BITS-1:0]               out_imm,
  output logic [TID_BITS-1:0]               out_tid,
  output logic [NR_BITS-1:0]                out_rd,
  output logic                              out_wb,
  output logic [FUNC3_BITS-1:0]             out_func3,
  output logic [FUNC7_BITS-1:0]             out_func7,
  output logic [BATCH_BITS-1:0]             out_batch,
  output logic [NUM_LANES-1:0][XLEN-1:0]    out_rs1_data,
  output logic [NUM_LANES-1:0][XLEN-1:0]    out_rs2_data,
  output logic                              out_eop
);

  if ((NUM_THREADS % NUM_LANES) != 0) begin : g_bad_lanes
    $error("vx_alu_req_batcher: NUM_THREADS must be a multiple of NUM_LANES");
  end

  logic [0:0]                       state_q, state_d;
  logic [BATCH_BITS-1:0]            cur_q, cur_d;
  logic [NUM_BATCHES-1:0]           bmask_q, bmask_d;
  req_side_t                        side_q, side_d;
  logic [TID_BITS-1:0]              tid_q, tid_d;
  logic [NUM_THREADS-1:0]           tmask_q, tmask_d;
  logic [NUM_THREADS-1:0][XLEN-1:0] rs1_q, rs1_d;
  logic [NUM_THREADS-1:0][XLEN-1:0] rs2_q, rs2_d;

  logic [NUM_BATCHES-1:0] in_bmask;
  logic [BATCH_BITS-1:0]  first_idx;
  logic [BATCH_BITS-1:0]  next_idx;
  logic                   last;
  logic                   accept;
  logic                   fire;

  for (genvar gi = 0; gi < NUM_BATCHES; gi++) begin : g_bmask
    assign in_bmask[gi] = |in_tmask[gi*NUM_LANES +: NUM_LANES];
  end

  // An all-zero mask falls through to batch 0 so the request still produces one beat.
  always_comb begin
    first_idx = '0;
    for (int b = NUM_BATCHES - 1; b >= 0; b--) begin
      if (in_bmask[b]) begin
        first_idx = BATCH_BITS'(b);
      end
    end
  end

  vx_alu_batch_sel #(
    .NUM_BATCHES (NUM_BATCHES),
    .BATCH_BITS  (BATCH_BITS)
  ) u_sel (
    .bmask_i (bmask_q),
    .cur_i   (cur_q),
    .next_o  (next_idx),
    .last_o  (last)
  );

  assign out_valid = (state_q == ST_ISSUE);
  assign out_eop   = out_valid && last;
  assign fire      = out_valid && out_ready;
  // Refill in the same cycle the final batch leaves, so requests stream without a bubble.
  assign in_ready  = reset && !flush && ((state_q == ST_IDLE) || (fire && last));
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    bmask_d = bmask_q;
    side_d  = side_q;
    tid_d   = tid_q;
    tmask_d = tmask_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      state_d        = ST_ISSUE;
      cur_d          = first_idx;
      bmask_d        = in_bmask;
      side_d.uuid    = in_uuid;
      side_d.wid     = in_wid;
      side_d.pc      = in_PC;
      side_d.next_pc = in_next_PC;
      side_d.op_type = in_op_type;
      side_d.op_mod  = in_op_mod;
      side_d.use_pc  = in_use_PC;
      side_d.use_imm = in_use_imm;
      side_d.imm     = in_imm;
      side_d.rd      = in_rd;
      side_d.wb      = in_wb;
      side_d.func3   = in_func3;
      side_d.func7   = in_func7;
      tid_d          = in_tid;
      tmask_d        = in_tmask;
      rs1_d          = in_rs1_data;
      rs2_d          = in_rs2_data;
    end else if (fire) begin
      if (last) begin
        state_d = ST_IDLE;
      end else begin
        cur_d = next_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      bmask_q <= '0;
      side_q  <= '0;
      tid_q   <= '0;
      tmask_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      bmask_q <= bmask_d;
      side_q  <= side_d;
      tid_q   <= tid_d;
      tmask_q <= tmask_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  assign out_uuid     = side_q.uuid;
  assign out_wid      = side_q.wid;
  assign out_PC       = side_q.pc;
  assign out_next_PC  = side_q.next_pc;
  assign out_op_type  = side_q.op_type;
  assign out_op_mod   = side_q.op_mod;
  assign out_use_PC   = side_q.use_pc;
  assign out_use_imm  = side_q.use_imm;
  assign out_imm      = side_q.imm;
  assign out_rd       = side_q.rd;
  assign out_wb       = side_q.wb;
  assign out_func3    = side_q.func3;
  assign out_func7    = side_q.func7;
  assign out_tid      = tid_q;
  assign out_batch    = cur_q;
  assign out_tmask    = tmask_q[cur_q*NUM_LANES +: NUM_LANES];
  assign out_rs1_data = rs1_q[cur_q*NUM_LANES +: NUM_LANES];
  assign out_rs2_data = rs2_q[cur_q*NUM_LANES +: NUM_LANES];

endmodule

// File: tb/tb_vx_alu_req_batcher.sv
// Directed bench for the ALU request batcher with 4 threads over 2 lanes.
module tb_vx_alu_req_batcher;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        in_valid, in_ready;
  logic [43:0] in_uuid;
  logic [1:0]  in_wid;
  logic [3:0]  in_tmask;
  logic [31:0] in_PC, in_next_PC;
  logic [3:0]  in_op_type;
  logic [2:0]  in_op_mod;
  logic        in_use_PC, in_use_imm;
  logic [31:0] in_imm;
  logic [1:0]  in_tid;
  logic [4:0]  in_rd;
  logic        in_wb;
  logic [2:0]  in_func3;
  logic [6:0]  in_func7;
  logic [3:0][31:0] in_rs1_data, in_rs2_data;

  logic        out_valid, out_ready;
  logic [43:0] out_uuid;
  logic [1:0]  out_wid;
  logic [1:0]  out_tmask;
  logic [31:0] out_PC, out_next_PC;
  logic [3:0]  out_op_type;
  logic [2:0]  out_op_mod;
  logic        out_use_PC, out_use_imm;
  logic [31:0] out_imm;
  logic [1:0]  out_tid;
  logic [4:0]  out_rd;
  logic        out_wb;
  logic [2:0]  out_func3;
  logic [6:0]  out_func7;
  logic [0:0]  out_batch;
  logic [1:0][31:0] out_rs1_data, out_rs2_data;
  logic        out_eop;

  int n_pass  = 0;
  int n_total = 0;

  // {valid, batch, tmask, eop}
  logic [4:0] st;
  assign st = {out_valid, out_batch, out_tmask, out_eop};

  always #5 clk = ~clk;

  vx_alu_req_batcher #(.NUM_THREADS(4), .NUM_LANES(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_uuid(in_uuid), .in_wid(in_wid), .in_tmask(in_tmask),
    .in_PC(in_PC), .in_next_PC(in_next_PC),
    .in_op_type(in_op_type), .in_op_mod(in_op_mod),
    .in_use_PC(in_use_PC), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_tid(in_tid), .in_rd(in_rd), .in_wb(in_wb),
    .in_func3(in_func3), .in_func7(in_func7),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_uuid(out_uuid), .out_wid(out_wid), .out_tmask(out_tmask),
    .out_PC(out_PC), .out_next_PC(out_next_PC),
    .out_op_type(out_op_type), .out_op_mod(out_op_mod),
    .out_use_PC(out_use_PC), .out_use_imm(out_use_imm), .out_imm(out_imm),
    .out_tid(out_tid), .out_rd(out_rd), .out_wb(out_wb),
    .out_func3(out_func3), .out_func7(out_func7),
    .out_batch(out_batch),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_eop(out_eop)
  );

  // Place a request on the input; operands are base+thread and base+0x10000000+thread.
  task automatic drive_req(input logic [43:0] uuid, input logic [3:0] tmask, input logic [31:0] base);
    in_uuid    = uuid;
    in_wid     = uuid[1:0];
    in_tmask   = tmask;
    in_PC      = 32'h8000_0000 + uuid[31:0];
    in_next_PC = 32'h8000_0004 + uuid[31:0];
    in_op_type = 4'h5;
    in_op_mod  = 3'h2;
    in_use_PC  = 1'b0;
    in_use_imm = 1'b1;
    in_imm     = 32'h0000_0123;
    in_tid     = 2'd1;
    in_rd      = 5'd7;
    in_wb      = 1'b1;
    in_func3   = 3'b101;
    in_func7   = 7'b010_0000;
    for (int t = 0; t < 4; t++) begin
      in_rs1_data[t] = base + 32'(t);
      in_rs2_data[t] = base + 32'h1000_0000 + 32'(t);
    end
    in_valid = 1'b1;
  endtask

  // Offer a request for one edge (caller ensures in_ready), leaving time at edge+1.
  task automatic send_req(input logic [43:0] uuid, input logic [3:0] tmask, input logic [31:0] base);
    drive_req(uuid, tmask, base);
    $display("req uuid=%h tmask=%b base=%h", uuid, tmask, base);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive_req(44'h0, 4'h0, 32'h0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({out_valid, out_eop, out_tmask, out_batch, out_uuid} !== 49'd0) $display("FAIL reset_outputs: got %h want 0", {out_valid, out_eop, out_tmask, out_batch, out_uuid});
    else n_pass++;
    n_total++;
    if ({out_rs1_data, out_rs2_data} !== 128'd0) $display("FAIL reset_data: got %h want 0", {out_rs1_data, out_rs2_data});
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_release: got %b want 10", {in_ready, out_valid});
    else n_pass++;
  endtask

  task automatic test_full_mask();
    out_ready = 1'b1;
    send_req(44'h111, 4'b1111, 32'hA000_0000);
    n_total++;
    if (st !== 5'b10110) $display("FAIL full_b0_status: got %b want 10110", st);
    else n_pass++;
    n_total++;
    if ({out_rs1_data, out_rs2_data} !== {64'hA000_0001_A000_0000, 64'hB000_0001_B000_0000}) $display("FAIL full_b0_data: got %h", {out_rs1_data, out_rs2_data});
    else n_pass++;
    n_total++;
    if ({out_uuid, out_wid, out_PC, out_rd, out_func3, out_func7, out_imm} !== {44'h111, 2'b01, 32'h8000_0111, 5'd7, 3'b101, 7'b010_0000, 32'h123}) $display("FAIL full_sideband: got uuid %h pc %h rd %0d", out_uuid, out_PC, out_rd);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (st !== 5'b11111) $display("FAIL full_b1_status: got %b want 11111", st);
    else n_pass++;
    n_total++;
    if ({out_rs1_data, out_rs2_data} !== {64'hA000_0003_A000_0002, 64'hB000_0003_B000_0002}) $display("FAIL full_b1_data: got %h", {out_rs1_data, out_rs2_data});
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({out_valid, in_ready} !== 2'b01) $display("FAIL full_done: got %b want 01", {out_valid, in_ready});
    else n_pass++;
  endtask

  task automatic test_skip_empty();
    out_ready = 1'b1;
    send_req(44'h222, 4'b0100, 32'hC000_0000);
    n_total++;
    if (st !== 5'b11011) $display("FAIL skip_status: got %b want 11011", st);
    else n_pass++;
    n_total++;
    if (out_rs1_data !== 64'hC000_0003_C000_0002) $display("FAIL skip_data: got %h want c0000003c0000002", out_rs1_data);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL skip_single: got valid %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_zero_mask();
    out_ready = 1'b1;
    send_req(44'h333, 4'b0000, 32'hD000_0000);
    n_total++;
    if ({st, out_uuid} !== {5'b10001, 44'h333}) $display("FAIL zero_status: got %b uuid %h want 10001 uuid 333", st, out_uuid);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL zero_single: got valid %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_req(44'h444, 4'b1111, 32'hE000_0000);
    for (int c = 0; c < 3; c++) begin
      n_total++;
      if ({st, in_ready, out_uuid, out_rs1_data} !== {5'b10110, 1'b0, 44'h444, 64'hE000_0001_E000_0000}) $display("FAIL stall_hold%0d: got st %b rdy %b rs1 %h", c, st, in_ready, out_rs1_data);
      else n_pass++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    n_total++;
    if ({st, out_rs2_data} !== {5'b10110, 64'hF000_0001_F000_0000}) $display("FAIL stall_release_b0: got st %b rs2 %h", st, out_rs2_data);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({st, out_rs1_data} !== {5'b11111, 64'hE000_0003_E000_0002}) $display("FAIL stall_b1: got st %b rs1 %h", st, out_rs1_data);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_req(44'h555, 4'b1111, 32'h1000_0000);
    drive_req(44'h666, 4'b1111, 32'h2000_0000);
    #1;
    n_total++;
    if ({st, in_ready, out_uuid} !== {5'b10110, 1'b0, 44'h555}) $display("FAIL b2b_c1: got st %b rdy %b uuid %h", st, in_ready, out_uuid);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({st, in_ready, out_uuid} !== {5'b11111, 1'b1, 44'h555}) $display("FAIL b2b_c2: got st %b rdy %b uuid %h", st, in_ready, out_uuid);
    else n_pass++;
    $display("req uuid=%h tmask=%b base=%h", in_uuid, in_tmask, in_rs1_data[0]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++;
    if ({st, out_uuid, out_rs1_data} !== {5'b10110, 44'h666, 64'h2000_0001_2000_0000}) $display("FAIL b2b_c3: got st %b uuid %h rs1 %h", st, out_uuid, out_rs1_data);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({st, out_uuid} !== {5'b11111, 44'h666}) $display("FAIL b2b_c4: got st %b uuid %h", st, out_uuid);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL b2b_end: got valid %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send_req(44'h777, 4'b1111, 32'h3000_0000);
    reset = 1'b0;
    #1;
    n_total++;
    if ({out_valid, in_ready} !== 2'b10) $display("FAIL rstmid_assert: got %b want 10", {out_valid, in_ready});
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({out_valid, out_eop, out_uuid} !== {2'b00, 44'h0}) $display("FAIL rstmid_cleared: got v %b e %b uuid %h", out_valid, out_eop, out_uuid);
    else n_pass++;
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL rstmid_no_replay: got valid %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send_req(44'h888, 4'b1111, 32'h4000_0000);
    drive_req(44'h999, 4'b1111, 32'h5000_0000);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    n_total++;
    if ({st, in_ready} !== {5'b10110, 1'b0}) $display("FAIL flush_in_ready: got st %b rdy %b", st, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL flush_drop: got valid %b want 0", out_valid);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL flush_no_b1_%0d: got valid %b batch %b", c, out_valid, out_batch);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_skip_empty();
    test_zero_mask();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
